// File: rtl/systolic_edge_feeder_if.sv
// systolic_edge_feeder_if: ready/valid vector stream feeding one systolic-array edge.
interface systolic_edge_feeder_if #(parameter int IP_size = 8, parameter int LANES = 4);
    logic in_valid;
    logic in_ready;
    logic in_last;
    logic [LANES*IP_size-1:0] in_data;
    modport master (output in_valid, in_last, in_data, input in_ready);
    modport slave (input in_valid, in_last, in_data, output in_ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: skews a beat stream onto the array edge lanes and flags tile completion.
module systolic_edge_feeder #(
    parameter int IP_size = 8,
    parameter int LANES = 4,
    parameter int PROP_DEPTH = 3,
    parameter int MAC_LAT = 4,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    systolic_edge_feeder_if.slave s,
    output logic [LANES*IP_size-1:0] x_out,
    output logic [LANES-1:0] en_out,
    output logic [LANES-1:0] clr_out,
    output logic busy,
    output logic tile_done,
    output logic [CNT_W-1:0] k_count
);
    localparam int DONE_LAT = LANES + PROP_DEPTH + MAC_LAT;
    localparam int FW = $clog2(DONE_LAT + 1);
    localparam logic [FW-1:0] LOAD = FW'(DONE_LAT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t state, state_n;
    logic [FW-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] k_n;
    logic done_n, acc;
    logic [LANES*IP_size-1:0] b_x;
    logic b_en, b_clr;

    assign s.in_ready = state != FLUSH;
    assign acc = s.in_valid && s.in_ready;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        k_n = k_count;
        done_n = 1'b0;
        case (state)
            IDLE: if (acc) begin
                k_n = CNT_W'(1);
                cnt_n = LOAD;
                state_n = s.in_last ? FLUSH : STREAM;
            end
            STREAM: if (acc) begin
                k_n = &k_count ? k_count : k_count + 1'b1;
                cnt_n = LOAD;
                state_n = s.in_last ? FLUSH : STREAM;
            end
            FLUSH: begin
                cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
                done_n = cnt == '0;
                state_n = (cnt == '0) ? IDLE : FLUSH;
            end
            default: state_n = IDLE;
        endcase
    end

    // b_* holds the accepted beat (or a bubble) one cycle; lane chains skew it from there
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            k_count <= '0;
            tile_done <= 1'b0;
            busy <= 1'b0;
            b_x <= '0;
            b_en <= 1'b0;
            b_clr <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            k_count <= k_n;
            tile_done <= done_n;
            busy <= state_n != IDLE;
            b_x <= acc ? s.in_data : '0;
            b_en <= acc;
            b_clr <= acc && state == IDLE;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IP_size-1:0] cx [i+1];
        logic [i:0] ce, cc;
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) cx[k] <= '0;
                ce <= '0;
                cc <= '0;
            end else begin
                cx[0] <= b_x[i*IP_size +: IP_size];
                ce[0] <= b_en;
                cc[0] <= b_clr;
                for (int k = 1; k <= i; k++) begin
                    cx[k] <= cx[k-1];
                    ce[k] <= ce[k-1];
                    cc[k] <= cc[k-1];
                end
            end
        end
        assign x_out[i*IP_size +: IP_size] = cx[i];
        assign en_out[i] = ce[i];
        assign clr_out[i] = cc[i];
    end
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder: table-driven tile check plus gap, single-beat, back-to-back and reset sequences.
module tb_systolic_edge_feeder;
    localparam int W = 8;
    localparam int L = 4;
    localparam logic [31:0] D1 = 32'h04030201;
    localparam logic [31:0] D2 = 32'h08070605;
    localparam logic [31:0] D3 = 32'h0c0b0a09;
    localparam logic [31:0] B1 = 32'h80ff7f81;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_edge_feeder_if #(.IP_size(W), .LANES(L)) bus ();
    logic [L*W-1:0] x_out;
    logic [L-1:0] en_out, clr_out;
    logic busy, tile_done;
    logic [15:0] k_count;

    systolic_edge_feeder #(.IP_size(W), .LANES(L), .PROP_DEPTH(3), .MAC_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s(bus), .x_out(x_out), .en_out(en_out), .clr_out(clr_out),
        .busy(busy), .tile_done(tile_done), .k_count(k_count)
    );

    typedef struct {
        logic v, l;
        logic [31:0] d;
        logic rdy, bsy, dn;
        logic [15:0] k;
        logic [3:0] en, clr;
        logic [31:0] x;
    } vec_t;

    vec_t tbl [15];
    logic [3:0] gexp [9];
    int checks = 0;
    int errors = 0;
    int n;
    int ec [L];
    int cc [L];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_last = l;
        bus.in_data = d;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].d);
            step();
            chk($sformatf("%s%0d.ready", tag, i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("%s%0d.busy", tag, i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("%s%0d.done", tag, i), 32'(tile_done), 32'(tbl[i].dn));
            chk($sformatf("%s%0d.k", tag, i), 32'(k_count), 32'(tbl[i].k));
            chk($sformatf("%s%0d.en", tag, i), 32'(en_out), 32'(tbl[i].en));
            chk($sformatf("%s%0d.clr", tag, i), 32'(clr_out), 32'(tbl[i].clr));
            chk($sformatf("%s%0d.x", tag, i), x_out, tbl[i].x);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, D1, 1'b1, 1'b1, 1'b0, 16'd1, 4'h0, 4'h0, 32'h00000000};
        tbl[1]  = '{1'b1, 1'b0, D2, 1'b1, 1'b1, 1'b0, 16'd2, 4'h1, 4'h1, 32'h00000001};
        tbl[2]  = '{1'b1, 1'b1, D3, 1'b0, 1'b1, 1'b0, 16'd3, 4'h3, 4'h2, 32'h00000205};
        tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd3, 4'h7, 4'h4, 32'h00030609};
        tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd3, 4'he, 4'h8, 32'h04070a00};
        tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd3, 4'hc, 4'h0, 32'h080b0000};
        tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd3, 4'h8, 4'h0, 32'h0c000000};
        for (int i = 7; i < 13; i++) tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd3, 4'h0, 4'h0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'd3, 4'h0, 4'h0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd3, 4'h0, 4'h0, 32'h0};
        gexp = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hc, 4'h8};

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle%0d.ready", i), 32'(bus.in_ready), 32'd1);
            chk($sformatf("idle%0d.outs", i), 32'({busy, tile_done, en_out, clr_out}), 32'd0);
            chk($sformatf("idle%0d.x", i), x_out, 32'h0);
            chk($sformatf("idle%0d.k", i), 32'(k_count), 32'd0);
        end

        run_table("t");

        // beat, two bubbles, beat, last beat: en gaps travel diagonally
        for (int e = 0; e < 5; e++) begin
            drive(e != 1 && e != 2, e == 4, e == 0 ? D1 : (e == 3 ? D2 : D3));
            step();
            if (e > 0) chk($sformatf("gap.en%0d", e), 32'(en_out), 32'(gexp[e]));
        end
        drive(1'b0, 1'b0, 32'h0);
        n = 0;
        do begin
            step();
            n++;
            if (4 + n <= 8) chk($sformatf("gap.en%0d", 4 + n), 32'(en_out), 32'(gexp[4 + n]));
        end while (!tile_done && n < 20);
        chk("gap.done_lat", 32'(n), 32'd11);
        chk("gap.k", 32'(k_count), 32'd3);

        drive(1'b1, 1'b1, D1);
        step();
        chk("single.busy", 32'(busy), 32'd1);
        chk("single.ready", 32'(bus.in_ready), 32'd0);
        chk("single.k", 32'(k_count), 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < L; i++) begin
            ec[i] = 0;
            cc[i] = 0;
        end
        n = 0;
        do begin
            step();
            n++;
            for (int i = 0; i < L; i++) begin
                ec[i] += int'(en_out[i]);
                cc[i] += int'(clr_out[i]);
            end
        end while (!tile_done && n < 20);
        chk("single.done_lat", 32'(n), 32'd11);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("single.en_cnt%0d", i), 32'(ec[i]), 32'd1);
            chk($sformatf("single.clr_cnt%0d", i), 32'(cc[i]), 32'd1);
        end

        // valid stays high through the flush; the held beat lands in the tile_done cycle
        drive(1'b1, 1'b0, D1);
        step();
        drive(1'b1, 1'b1, D2);
        step();
        drive(1'b1, 1'b0, B1);
        n = 0;
        do begin
            step();
            n++;
            if (!tile_done) begin
                chk($sformatf("b2b.hold_k%0d", n), 32'(k_count), 32'd2);
                chk($sformatf("b2b.hold_ready%0d", n), 32'(bus.in_ready), 32'd0);
            end
        end while (!tile_done && n < 20);
        chk("b2b.done_lat", 32'(n), 32'd11);
        chk("b2b.done_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("b2b.k1", 32'(k_count), 32'd1);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.done_low", 32'(tile_done), 32'd0);
        drive(1'b1, 1'b1, B1);
        step();
        chk("b2b.en0", 32'(en_out[0]), 32'd1);
        chk("b2b.clr0", 32'(clr_out[0]), 32'd1);
        chk("b2b.x0", 32'(x_out[7:0]), 32'h81);
        chk("b2b.k2", 32'(k_count), 32'd2);
        drive(1'b0, 1'b0, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.x", x_out, 32'h0);
        chk("rst.outs", 32'({busy, tile_done, en_out, clr_out}), 32'd0);
        chk("rst.k", 32'(k_count), 32'd0);
        chk("rst.ready", 32'(bus.in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            n += int'(tile_done);
        end
        chk("rst.no_done", 32'(n), 32'd0);

        run_table("r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
